// File: rtl/hwdet_pkg.sv
// Shared types and helpers for the multi-channel pulse-width detector.
package hwdet_pkg;

    // Per-channel measurement state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_e;

    // Default counter width and its saturation value.
    localparam int                      CW_DEFAULT = 32;
    localparam logic [CW_DEFAULT-1:0]   CW_MAX     = '1;

    // Width of the channel-select bus; never narrower than one bit.
    function automatic int sel_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/hwdet_chan.sv
// One detector channel: 2-FF synchroniser, glitch filter, edge detect,
// IDLE/HIGH/LOW measurement FSM with saturating counters and a latched pair.
module hwdet_chan
    import hwdet_pkg::*;
#(
    parameter int CW   = CW_DEFAULT,
    parameter int FILT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    input  logic          en,
    output logic [CW-1:0] high_lat,
    output logic [CW-1:0] low_lat,
    output logic          valid,
    output logic          stuck_hi,
    output logic          stuck_lo,
    output logic          new_sample
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic lvl;
    logic lvl_prev_q, lvl_prev_d;
    logic rise, fall;

    // Synchroniser chain and previous filtered level for edge detection.
    always_comb begin
        sync1_d    = pwm_in;
        sync2_d    = sync1_q;
        lvl_prev_d = lvl;
    end

    // Synchroniser and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_prev_q <= lvl_prev_d;
        end
    end

    // Glitch filter: the level only moves once FILT consecutive samples agree,
    // which delays both edges equally so pulse widths are preserved.
    generate
        if (FILT == 0) begin : g_bypass
            assign lvl = sync2_q;
        end else begin : g_filt
            logic [FILT-1:0] win;
            logic            filt_q, filt_d;

            if (FILT == 1) begin : g_one
                assign win = sync2_q;
            end else begin : g_hist
                logic [FILT-2:0] hist_q, hist_d;

                // Shift history of synchronised samples.
                always_comb begin
                    hist_d    = hist_q << 1;
                    hist_d[0] = sync2_q;
                end

                // History register.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) hist_q <= '0;
                    else        hist_q <= hist_d;
                end

                assign win = {hist_q, sync2_q};
            end

            // Accept a new level only when the whole window agrees.
            always_comb begin
                filt_d = filt_q;
                if (&win)       filt_d = 1'b1;
                else if (~|win) filt_d = 1'b0;
            end

            // Filtered level register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) filt_q <= 1'b0;
                else        filt_q <= filt_d;
            end

            assign lvl = filt_q;
        end
    endgenerate

    assign rise = lvl & ~lvl_prev_q;
    assign fall = ~lvl & lvl_prev_q;

    chan_state_e   state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] hshadow_q, hshadow_d;
    logic [CW-1:0] high_lat_q, high_lat_d;
    logic [CW-1:0] low_lat_q, low_lat_d;
    logic          valid_q, valid_d;
    logic          stuck_hi_q, stuck_hi_d;
    logic          stuck_lo_q, stuck_lo_d;
    logic          new_sample_q, new_sample_d;

    // Measurement FSM: the edge cycle is cycle 1 of the new level; an edge
    // always beats saturation; the latched pair is only written on commit.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        hshadow_d    = hshadow_q;
        high_lat_d   = high_lat_q;
        low_lat_d    = low_lat_q;
        valid_d      = valid_q;
        stuck_hi_d   = stuck_hi_q;
        stuck_lo_d   = stuck_lo_q;
        new_sample_d = 1'b0;

        if (!en) begin
            state_d    = ST_IDLE;
            hcnt_d     = '0;
            lcnt_d     = '0;
            hshadow_d  = '0;
            high_lat_d = '0;
            low_lat_d  = '0;
            valid_d    = 1'b0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        hcnt_d  = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        hshadow_d  = hcnt_q;
                        lcnt_d     = CNT_ONE;
                        stuck_hi_d = 1'b0;
                        state_d    = ST_LOW;
                    end else begin
                        if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
                        if (hcnt_q == CNT_PRE || hcnt_q == CNT_MAX) stuck_hi_d = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_lat_d   = hshadow_q;
                        low_lat_d    = lcnt_q;
                        new_sample_d = 1'b1;
                        valid_d      = 1'b1;
                        hcnt_d       = CNT_ONE;
                        stuck_lo_d   = 1'b0;
                        state_d      = ST_HIGH;
                    end else begin
                        if (lcnt_q != CNT_MAX) lcnt_d = lcnt_q + CNT_ONE;
                        if (lcnt_q == CNT_PRE || lcnt_q == CNT_MAX) stuck_lo_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM, counter, shadow and latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            hshadow_q    <= '0;
            high_lat_q   <= '0;
            low_lat_q    <= '0;
            valid_q      <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
            new_sample_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            hshadow_q    <= hshadow_d;
            high_lat_q   <= high_lat_d;
            low_lat_q    <= low_lat_d;
            valid_q      <= valid_d;
            stuck_hi_q   <= stuck_hi_d;
            stuck_lo_q   <= stuck_lo_d;
            new_sample_q <= new_sample_d;
        end
    end

    assign high_lat   = high_lat_q;
    assign low_lat    = low_lat_q;
    assign valid      = valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;
    assign new_sample = new_sample_q;

endmodule

// File: rtl/hwdet_multi.sv
// Multi-channel pulse-width detector: NCH channel instances plus a registered
// read mux selecting one channel's latched results for software.
module hwdet_multi
    import hwdet_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CW   = CW_DEFAULT,
    parameter int FILT = 2,
    parameter int SELW = sel_width(NCH)
) (
    input  logic            sysclk,
    input  logic            sysreset_n,
    input  logic [NCH-1:0]  pwm_in,
    input  logic [NCH-1:0]  ch_en,
    input  logic [SELW-1:0] sel,
    output logic [CW-1:0]   high_cnt,
    output logic [CW-1:0]   low_cnt,
    output logic            meas_valid,
    output logic            stuck_hi,
    output logic            stuck_lo,
    output logic [NCH-1:0]  new_sample
);

    logic [CW-1:0] ch_high  [NCH];
    logic [CW-1:0] ch_low   [NCH];
    logic          ch_valid [NCH];
    logic          ch_shi   [NCH];
    logic          ch_slo   [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            hwdet_chan #(
                .CW   (CW),
                .FILT (FILT)
            ) u_chan (
                .clk        (sysclk),
                .rst_n      (sysreset_n),
                .pwm_in     (pwm_in[gi]),
                .en         (ch_en[gi]),
                .high_lat   (ch_high[gi]),
                .low_lat    (ch_low[gi]),
                .valid      (ch_valid[gi]),
                .stuck_hi   (ch_shi[gi]),
                .stuck_lo   (ch_slo[gi]),
                .new_sample (new_sample[gi])
            );
        end
    endgenerate

    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic          meas_valid_q, meas_valid_d;
    logic          stuck_hi_q, stuck_hi_d;
    logic          stuck_lo_q, stuck_lo_d;

    // Select one channel; out-of-range selects read as zero. The high/low
    // pair is taken from the same cycle so it always belongs to one period.
    always_comb begin
        high_cnt_d   = '0;
        low_cnt_d    = '0;
        meas_valid_d = 1'b0;
        stuck_hi_d   = 1'b0;
        stuck_lo_d   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(sel) == i) begin
                high_cnt_d   = ch_high[i];
                low_cnt_d    = ch_low[i];
                meas_valid_d = ch_valid[i];
                stuck_hi_d   = ch_shi[i];
                stuck_lo_d   = ch_slo[i];
            end
        end
    end

    // Read-mux output registers.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
        end else begin
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            meas_valid_q <= meas_valid_d;
            stuck_hi_q   <= stuck_hi_d;
            stuck_lo_q   <= stuck_lo_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign low_cnt    = low_cnt_q;
    assign meas_valid = meas_valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_hwdet_multi.sv
// Bench for hwdet_multi: waveforms are built as per-channel sample arrays,
// played one sample per cycle, and compared against a pulse-width model that
// works on run lengths of the applied samples.
module tb_hwdet_multi;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int FILT = 2;
    localparam int SELW = 3;
    localparam int MAXT = 4096;
    localparam int CMAX = 255;

    logic            sysclk = 1'b0;
    logic            sysreset_n = 1'b0;
    logic [NCH-1:0]  pwm_in = '0;
    logic [NCH-1:0]  ch_en = '1;
    logic [SELW-1:0] sel = '0;
    logic [CW-1:0]   high_cnt, low_cnt;
    logic            meas_valid, stuck_hi, stuck_lo;
    logic [NCH-1:0]  new_sample;

    hwdet_multi #(.NCH(NCH), .CW(CW), .FILT(FILT), .SELW(SELW)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .pwm_in     (pwm_in),
        .ch_en      (ch_en),
        .sel        (sel),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .meas_valid (meas_valid),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo),
        .new_sample (new_sample)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;
    bit wave [NCH][MAXT];
    int wlen [NCH];
    int cur;
    int pulses [NCH];
    int off_t [NCH];
    int on_t [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic add_seg(input int c, input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (wlen[c] >= MAXT) begin
                $display("FAIL wave_overflow: got %0d, expected < %0d", wlen[c], MAXT);
                $fatal(1, "wave buffer exhausted");
            end
            wave[c][wlen[c]] = v;
            wlen[c]++;
        end
    endtask

    // One cycle: count commit pulses, then drive the next sample (holding
    // the last level once a channel's waveform runs out).
    task automatic tick();
        bit lvl;
        @(negedge sysclk);
        if (cur >= MAXT) begin
            $display("FAIL time_overflow: got %0d, expected < %0d", cur, MAXT);
            $fatal(1, "timeline exhausted");
        end
        for (int c = 0; c < NCH; c++) begin
            if (new_sample[c]) pulses[c]++;
            if (wlen[c] > cur)  lvl = wave[c][cur];
            else if (cur > 0)   lvl = wave[c][cur-1];
            else                lvl = 1'b0;
            wave[c][cur] = lvl;
            if (wlen[c] <= cur) wlen[c] = cur + 1;
            pwm_in[c] = lvl;
        end
        cur++;
    endtask

    task automatic play(input int extra);
        int m;
        m = 0;
        for (int c = 0; c < NCH; c++) if (wlen[c] > m) m = wlen[c];
        while (cur < m) tick();
        repeat (extra) tick();
    endtask

    task automatic do_reset();
        pwm_in = '0;
        ch_en  = '1;
        sel    = '0;
        @(negedge sysclk);
        sysreset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        sysreset_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            wlen[c]   = 0;
            pulses[c] = 0;
            off_t[c]  = -1;
            on_t[c]   = -1;
        end
        cur = 0;
        play(8);
    endtask

    // Model: filtered edges are the starts of runs of at least FILT samples
    // at a new level; widths are distances between those edges, capped at CMAX.
    task automatic model(input int c, output int ncom, output int ehi, output int elo,
                         output int evalid, output int shi, output int shi_known,
                         output int slo, output int slo_known);
        int  st, cl, t, r, hstart, lstart, hw, last_e, elapsed;
        bit  v, off_done, skip;
        st = 0; cl = 0; t = 0; hstart = 0; lstart = 0; hw = 0; last_e = 0;
        off_done = 0;
        ncom = 0; ehi = 0; elo = 0; evalid = 0;
        while (t < cur) begin
            v = wave[c][t];
            r = 1;
            while (t + r < cur && wave[c][t+r] == v) r++;
            if (int'(v) != cl && r >= FILT) begin
                cl = int'(v);
                if (off_t[c] >= 0 && !off_done && t >= off_t[c]) begin
                    off_done = 1; st = 0; ehi = 0; elo = 0; evalid = 0;
                end
                skip = (off_t[c] >= 0) && (t >= off_t[c]) && (on_t[c] < 0 || t < on_t[c]);
                if (!skip) begin
                    if (v) begin
                        if (st == 2) begin
                            ncom++;
                            ehi = hw;
                            elo = (t - lstart > CMAX) ? CMAX : t - lstart;
                            evalid = 1;
                        end
                        if (st != 1) begin st = 1; hstart = t; last_e = t; end
                    end else if (st == 1) begin
                        hw = (t - hstart > CMAX) ? CMAX : t - hstart;
                        st = 2; lstart = t; last_e = t;
                    end
                end
            end
            t += r;
        end
        if (off_t[c] >= 0 && !off_done && off_t[c] <= cur) begin
            st = 0; ehi = 0; elo = 0; evalid = 0;
        end
        elapsed   = cur - last_e;
        shi       = (st == 1 && elapsed >= CMAX) ? 1 : 0;
        slo       = (st == 2 && elapsed >= CMAX) ? 1 : 0;
        shi_known = (st != 1 || elapsed >= CMAX + 20 || elapsed <= CMAX - 20) ? 1 : 0;
        slo_known = (st != 2 || elapsed >= CMAX + 20 || elapsed <= CMAX - 20) ? 1 : 0;
    endtask

    task automatic check_chan(input int c, input string tag);
        int ncom, ehi, elo, ev, shi, shk, slo, slk;
        sel = SELW'(c);
        tick();
        model(c, ncom, ehi, elo, ev, shi, shk, slo, slk);
        $display("read %s ch%0d: high=%0d low=%0d valid=%0d shi=%0d slo=%0d pulses=%0d",
                 tag, c, high_cnt, low_cnt, meas_valid, stuck_hi, stuck_lo, pulses[c]);
        chk($sformatf("%s_ch%0d_high", tag, c), 32'(high_cnt), ehi);
        chk($sformatf("%s_ch%0d_low", tag, c), 32'(low_cnt), elo);
        chk($sformatf("%s_ch%0d_valid", tag, c), 32'(meas_valid), ev);
        chk($sformatf("%s_ch%0d_pulses", tag, c), 32'(pulses[c]), ncom);
        if (shk != 0) chk($sformatf("%s_ch%0d_stuck_hi", tag, c), 32'(stuck_hi), shi);
        if (slk != 0) chk($sformatf("%s_ch%0d_stuck_lo", tag, c), 32'(stuck_lo), slo);
    endtask

    task automatic check_sel_zero(input int s, input string tag);
        sel = SELW'(s);
        tick();
        $display("read %s sel=%0d: high=%0d low=%0d valid=%0d", tag, s, high_cnt, low_cnt, meas_valid);
        chk($sformatf("%s_sel%0d_high", tag, s), 32'(high_cnt), 0);
        chk($sformatf("%s_sel%0d_low", tag, s), 32'(low_cnt), 0);
        chk($sformatf("%s_sel%0d_flags", tag, s), {29'd0, meas_valid, stuck_hi, stuck_lo}, 0);
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++) check_chan(c, tag);
        check_sel_zero(4, tag);
    endtask

    task automatic rand_wave();
        int h, l, a;
        for (int c = 0; c < NCH; c++) begin
            add_seg(c, 1'b0, 5 + c);
            for (int k = 0; k < 6; k++) begin
                h = $urandom_range(3, 60);
                l = $urandom_range(3, 60);
                if (c == 3 && k == 2) h = $urandom_range(250, 300);
                if (h >= 6 && $urandom_range(0, 1) == 1) begin
                    a = $urandom_range(2, h - 4);
                    add_seg(c, 1'b1, a); add_seg(c, 1'b0, 1); add_seg(c, 1'b1, h - a - 1);
                end else add_seg(c, 1'b1, h);
                if (l >= 6 && $urandom_range(0, 1) == 1) begin
                    a = $urandom_range(2, l - 4);
                    add_seg(c, 1'b0, a); add_seg(c, 1'b1, 1); add_seg(c, 1'b0, l - a - 1);
                end else add_seg(c, 1'b0, l);
            end
            add_seg(c, 1'b1, 10);
            add_seg(c, 1'b0, 20);
        end
    endtask

    initial begin
        // Reset state.
        do_reset();
        sel = '0;
        tick();
        chk("reset_high", 32'(high_cnt), 0);
        chk("reset_low", 32'(low_cnt), 0);
        chk("reset_flags", {29'd0, meas_valid, stuck_hi, stuck_lo}, 0);
        chk("reset_new_sample", 32'(new_sample), 0);

        // Basic: 100 high / 300 low (low saturates at 255), ending stuck low.
        add_seg(0, 1'b0, 10);
        for (int k = 0; k < 3; k++) begin
            add_seg(0, 1'b1, 100);
            add_seg(0, 1'b0, 300);
        end
        add_seg(0, 1'b1, 100);
        add_seg(0, 1'b0, 300);
        play(12);
        check_all("basic");

        // Asynchronous reset between clock edges clears outputs at once.
        sel = '0;
        tick();
        #2;
        sysreset_n = 1'b0;
        #1;
        $display("async reset: high=%0d low=%0d valid=%0d slo=%0d", high_cnt, low_cnt, meas_valid, stuck_lo);
        chk("async_rst_high", 32'(high_cnt), 0);
        chk("async_rst_low", 32'(low_cnt), 0);
        chk("async_rst_flags", {29'd0, meas_valid, stuck_hi, stuck_lo}, 0);
        chk("async_rst_new_sample", 32'(new_sample), 0);

        // Filter: 1-cycle glitches ignored, 3-cycle pulse accepted.
        do_reset();
        add_seg(0, 1'b0, 10);
        add_seg(0, 1'b1, 20); add_seg(0, 1'b0, 1); add_seg(0, 1'b1, 15);
        add_seg(0, 1'b0, 1);  add_seg(0, 1'b1, 13);
        add_seg(0, 1'b0, 3);  add_seg(0, 1'b1, 10); add_seg(0, 1'b0, 20);
        add_seg(1, 1'b0, 5);  add_seg(1, 1'b1, 30);
        add_seg(1, 1'b0, 12); add_seg(1, 1'b1, 1);  add_seg(1, 1'b0, 12);
        add_seg(1, 1'b1, 30); add_seg(1, 1'b0, 10);
        play(12);
        check_all("filter");

        // Stuck high on ch1, then recovery and a saturated commit.
        do_reset();
        add_seg(1, 1'b0, 10); add_seg(1, 1'b1, 30); add_seg(1, 1'b0, 30);
        add_seg(1, 1'b1, 300);
        play(5);
        check_all("stuck_a");
        add_seg(1, 1'b1, 100); add_seg(1, 1'b0, 20);
        add_seg(1, 1'b1, 15);  add_seg(1, 1'b0, 20);
        play(12);
        check_all("stuck_b");

        // Multi-channel: 10/20/30/40 high with 60 low, read each select.
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            add_seg(c, 1'b0, 5);
            for (int k = 0; k < 3; k++) begin
                add_seg(c, 1'b1, 10 * (c + 1));
                add_seg(c, 1'b0, 60);
            end
            add_seg(c, 1'b1, 10 * (c + 1));
            add_seg(c, 1'b0, 30);
        end
        play(12);
        check_all("multi");
        check_sel_zero(7, "multi");

        // Random widths with occasional glitches and one long high on ch3.
        for (int it = 0; it < 2; it++) begin
            do_reset();
            rand_wave();
            play(12);
            check_all($sformatf("rand%0d", it));
        end

        // Enable: drop ch2 mid-high, then re-enable and require a full period.
        do_reset();
        add_seg(2, 1'b0, 10);
        for (int k = 0; k < 2; k++) begin
            add_seg(2, 1'b1, 20);
            add_seg(2, 1'b0, 30);
        end
        add_seg(2, 1'b1, 30);
        play(0);
        check_chan(2, "en_before");
        ch_en[2] = 1'b0;
        off_t[2] = cur;
        sel = 3'd2;
        tick();
        tick();
        $display("ch_en drop: valid=%0d high=%0d", meas_valid, high_cnt);
        chk("en_drop_valid", 32'(meas_valid), 0);
        chk("en_drop_high", 32'(high_cnt), 0);
        add_seg(2, 1'b1, 30);
        add_seg(2, 1'b0, 40);
        play(0);
        ch_en[2] = 1'b1;
        on_t[2] = cur;
        add_seg(2, 1'b0, 20); add_seg(2, 1'b1, 25); add_seg(2, 1'b0, 35);
        play(12);
        check_chan(2, "en_half");
        add_seg(2, 1'b1, 25); add_seg(2, 1'b0, 15);
        play(12);
        check_chan(2, "en_full");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
